// File: rtl/ped_crossing_fsm.sv
// Pedestrian-crossing light sequencer: latches a crossing request, enforces a minimum car green,
// then runs yellow -> all-red -> walk -> [flashing walk] -> clearance -> car green.
// Latency: a request seen with min green already served reaches CAR_YELLOW two edges later.
// Backpressure: none. Presses during PED_WALK are dropped; repeated presses while pending merge.
//
// Optional feature macro: PED_FLASH_EN. When it is defined, the PED_FLASH state is built.
// When it is not defined, PED_WALK goes straight to PED_CLEAR and no flash logic exists.
//
// Ports:
//   clk          system clock; all state changes happen on the rising edge
//   rst          asynchronous reset, active low
//   ped_request  single-cycle debounced press pulse
//   car_red/car_yellow/car_green, ped_red/ped_green  Moore lamp outputs
//   ped_wait     "request pending" lamp; this is the request latch
//   state        current state code, for debug
module ped_crossing_fsm #(
    parameter int unsigned T_MIN_GREEN = 250000000,
    parameter int unsigned T_YELLOW    = 150000000,
    parameter int unsigned T_ALL_RED   = 50000000,
    parameter int unsigned T_WALK      = 400000000,
    parameter int unsigned T_FLASH     = 150000000,
    parameter int unsigned FLASH_HALF  = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_request,
    output logic       car_red,
    output logic       car_yellow,
    output logic       car_green,
    output logic       ped_red,
    output logic       ped_green,
    output logic       ped_wait,
    output logic [2:0] state
);

    // Every dwell must be at least one cycle, or the "last cycle" compares below never match.
    if (T_MIN_GREEN < 1 || T_YELLOW < 1 || T_ALL_RED < 1 || T_WALK < 1 ||
        T_FLASH < 1 || FLASH_HALF < 1) begin : g_bad_param
        $error("ped_crossing_fsm: all timing parameters must be >= 1");
    end

    typedef enum logic [2:0] {
        CAR_GREEN  = 3'd0,
        CAR_YELLOW = 3'd1,
        ALL_RED    = 3'd2,
        PED_WALK   = 3'd3,
        PED_FLASH  = 3'd4,
        PED_CLEAR  = 3'd5
    } state_e;

    localparam logic [31:0] MIN_GREEN_LAST = 32'(T_MIN_GREEN - 1);
    localparam logic [31:0] YELLOW_LAST    = 32'(T_YELLOW - 1);
    localparam logic [31:0] ALL_RED_LAST   = 32'(T_ALL_RED - 1);
    localparam logic [31:0] WALK_LAST      = 32'(T_WALK - 1);

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic        latch_q, latch_d;
    logic        min_done;
    logic        state_chg;

    // The green timer parks on its last value, so this stays high while green is held.
    assign min_done  = (timer_q == MIN_GREEN_LAST);
    assign state_chg = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            CAR_GREEN:  if (latch_q && min_done)      state_d = CAR_YELLOW;
            CAR_YELLOW: if (timer_q == YELLOW_LAST)   state_d = ALL_RED;
            ALL_RED:    if (timer_q == ALL_RED_LAST)  state_d = PED_WALK;
`ifdef PED_FLASH_EN
            PED_WALK:   if (timer_q == WALK_LAST)     state_d = PED_FLASH;
            PED_FLASH:  if (timer_q == 32'(T_FLASH - 1)) state_d = PED_CLEAR;
`else
            PED_WALK:   if (timer_q == WALK_LAST)     state_d = PED_CLEAR;
`endif
            PED_CLEAR:  if (timer_q == ALL_RED_LAST)  state_d = CAR_GREEN;
            // Unused codes (and PED_FLASH when not built) recover to car green.
            default:                                  state_d = CAR_GREEN;
        endcase
    end

    always_comb begin
        timer_d = timer_q + 32'd1;
        if (state_chg) begin
            timer_d = 32'd0;
        end else if (state_q == CAR_GREEN && min_done) begin
            timer_d = timer_q;
        end
    end

    // Clearing on walk entry takes priority over a press arriving on that same edge.
    always_comb begin
        latch_d = latch_q;
        if (ped_request && state_q != PED_WALK) begin
            latch_d = 1'b1;
        end
        if (state_chg && state_d == PED_WALK) begin
            latch_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CAR_GREEN;
            timer_q <= 32'd0;
            latch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            latch_q <= latch_d;
        end
    end

`ifdef PED_FLASH_EN
    localparam logic [31:0] FLASH_HALF_LAST = 32'(FLASH_HALF - 1);

    logic        flash_q, flash_d;
    logic [31:0] half_q, half_d;

    // Flash starts lit on entry and flips every FLASH_HALF cycles spent in PED_FLASH.
    always_comb begin
        flash_d = flash_q;
        half_d  = half_q;
        if (state_chg && state_d == PED_FLASH) begin
            flash_d = 1'b1;
            half_d  = 32'd0;
        end else if (state_q == PED_FLASH) begin
            if (half_q == FLASH_HALF_LAST) begin
                flash_d = ~flash_q;
                half_d  = 32'd0;
            end else begin
                half_d  = half_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flash_q <= 1'b0;
            half_q  <= 32'd0;
        end else begin
            flash_q <= flash_d;
            half_q  <= half_d;
        end
    end
`endif

    // Moore lamp decode from the registered state only.
    always_comb begin
        car_red    = 1'b0;
        car_yellow = 1'b0;
        car_green  = 1'b0;
        ped_red    = 1'b0;
        ped_green  = 1'b0;
        case (state_q)
            CAR_GREEN: begin
                car_green = 1'b1;
                ped_red   = 1'b1;
            end
            CAR_YELLOW: begin
                car_yellow = 1'b1;
                ped_red    = 1'b1;
            end
            ALL_RED, PED_CLEAR: begin
                car_red = 1'b1;
                ped_red = 1'b1;
            end
            PED_WALK: begin
                car_red   = 1'b1;
                ped_green = 1'b1;
            end
`ifdef PED_FLASH_EN
            PED_FLASH: begin
                car_red   = 1'b1;
                ped_green = flash_q;
            end
`endif
            default: begin
                car_red = 1'b1;
                ped_red = 1'b1;
            end
        endcase
    end

    assign ped_wait = latch_q;
    assign state    = state_q;

endmodule

// File: tb/tb_ped_crossing_fsm.sv
// Bench for ped_crossing_fsm: directed crossing scenarios plus random presses and resets,
// compared every cycle against a phase/age reference model.
// Works with or without PED_FLASH_EN defined.
module tb_ped_crossing_fsm;

    localparam int TMG = 8;
    localparam int TY  = 3;
    localparam int TAR = 2;
    localparam int TW  = 6;
    localparam int TF  = 4;
    localparam int FH  = 1;
`ifdef PED_FLASH_EN
    localparam bit HAS_FLASH = 1'b1;
`else
    localparam bit HAS_FLASH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ped_request = 1'b0;
    logic       car_red, car_yellow, car_green, ped_red, ped_green, ped_wait;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    ped_crossing_fsm #(
        .T_MIN_GREEN(TMG), .T_YELLOW(TY), .T_ALL_RED(TAR),
        .T_WALK(TW), .T_FLASH(TF), .FLASH_HALF(FH)
    ) dut (
        .clk(clk), .rst(rst), .ped_request(ped_request),
        .car_red(car_red), .car_yellow(car_yellow), .car_green(car_green),
        .ped_red(ped_red), .ped_green(ped_green), .ped_wait(ped_wait),
        .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: phase number, cycles already spent in it, pending request.
    int m_phase = 0;
    int m_age   = 0;
    bit m_req   = 1'b0;
    int dur[6]  = '{TMG, TY, TAR, TW, TF, TAR};

    function automatic int next_phase(input int p);
        case (p)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return HAS_FLASH ? 4 : 5;
            4: return 5;
            default: return 0;
        endcase
    endfunction

    function automatic void model_reset();
        m_phase = 0;
        m_age   = 0;
        m_req   = 1'b0;
    endfunction

    function automatic void model_step(input bit p);
        bit leave;
        bit new_req;
        if (m_phase == 0) leave = m_req && (m_age >= TMG - 1);
        else              leave = (m_age == dur[m_phase] - 1);
        new_req = m_req | (p && m_phase != 3);
        if (leave) begin
            m_phase = next_phase(m_phase);
            m_age   = 0;
            if (m_phase == 3) new_req = 1'b0;
        end else begin
            m_age++;
        end
        m_req = new_req;
    endfunction

    // {car_red, car_yellow, car_green, ped_red, ped_green, ped_wait}
    function automatic logic [5:0] exp_lamps();
        logic cr, cy, cg, pr, pg;
        {cr, cy, cg, pr, pg} = 5'b0;
        case (m_phase)
            0: begin cg = 1'b1; pr = 1'b1; end
            1: begin cy = 1'b1; pr = 1'b1; end
            3: begin cr = 1'b1; pg = 1'b1; end
            4: begin cr = 1'b1; pg = (((m_age / FH) % 2) == 0); end
            default: begin cr = 1'b1; pr = 1'b1; end
        endcase
        return {cr, cy, cg, pr, pg, m_req};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".state"}, {29'd0, state}, m_phase);
        check_val({tag, ".lamps"},
                  {26'd0, car_red, car_yellow, car_green, ped_red, ped_green, ped_wait},
                  {26'd0, exp_lamps()});
    endtask

    // One clock cycle with the given press value, then compare 1 time unit after the edge.
    task automatic cycle(input bit p);
        ped_request = p;
        @(posedge clk);
        model_step(p);
        #1;
        ped_request = 1'b0;
        check_outputs("cyc");
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    // Advance with no presses until the model sits in phase ph at age a (bounded).
    task automatic run_until(input int ph, input int a);
        int n = 0;
        while (!(m_phase == ph && m_age == a) && n < 200) begin
            cycle(1'b0);
            n++;
        end
        check_val("reach_phase", m_phase, ph);
    endtask

    // Asynchronous reset asserted mid-cycle, held across one rising edge.
    task automatic async_reset();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_now");
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Power-on reset.
        #12;
        check_outputs("por");
        @(negedge clk);
        rst = 1'b1;

        // No request: green held, timer saturated.
        run_idle(50);

        // Press long after min green: ped_wait next cycle, then full crossing.
        async_reset();
        run_idle(20);
        cycle(1'b1);
        check_val("wait_next", {31'd0, ped_wait}, 32'd1);
        run_idle(30);

        // Early press: green still lasts exactly the minimum.
        async_reset();
        run_idle(2);
        cycle(1'b1);
        run_idle(20);

        // Press during walk is ignored; press during clear is served next time round.
        async_reset();
        cycle(1'b1);
        run_until(3, 2);
        cycle(1'b1);
        check_val("walk_press_ignored", {31'd0, ped_wait}, 32'd0);
        run_until(5, 0);
        cycle(1'b1);
        check_val("clear_press_latched", {31'd0, ped_wait}, 32'd1);
        run_idle(45);

        // Press exactly on the ALL_RED -> PED_WALK edge loses to the clear.
        async_reset();
        cycle(1'b1);
        run_until(2, TAR - 1);
        cycle(1'b1);
        check_val("coinc_state", {29'd0, state}, 32'd3);
        check_val("coinc_wait", {31'd0, ped_wait}, 32'd0);
        run_idle(40);

        // Reset in the middle of walk.
        async_reset();
        cycle(1'b1);
        run_until(3, 3);
        async_reset();
        run_idle(10);

        // Random presses with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 499) == 0) async_reset();
            cycle($urandom_range(0, 11) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ped_crossing_fsm.md
# ped_crossing_fsm

Pedestrian-crossing light sequencer that consumes the single-cycle debounced press pulse from the button debouncer and drives the car and pedestrian lamp outputs. It latches a crossing request, enforces a minimum car-green time, and steps through a fixed phase sequence: yellow, all-red, walk, optional flashing walk, clearance. It sits directly downstream of the debouncer and upstream of the lamp output pins. All phase durations are counted in clock cycles by one shared phase timer.

## Interface

- T_MIN_GREEN, 250000000, minimum car-green dwell in cycles (5 s at 50 MHz)
- T_YELLOW, 150000000, car-yellow dwell in cycles
- T_ALL_RED, 50000000, all-red dwell in cycles, used before walk and after walk
- T_WALK, 400000000, steady pedestrian-green dwell in cycles
- T_FLASH, 150000000, flashing pedestrian-green dwell in cycles
- FLASH_HALF, 12500000, half-period of the flash in cycles
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- ped_request  input  1  single-cycle press pulse from the debouncer
- car_red / car_yellow / car_green  output  1 each  car lamps
- ped_red / ped_green  output  1 each  pedestrian lamps
- ped_wait  output  1  "request pending" lamp; equals the request latch
- state  output  3  current state encoding, for debug

All parameters must be ≥1. The phase timer is 32 bits wide.

## Operation

- States: CAR_GREEN=0, CAR_YELLOW=1, ALL_RED=2, PED_WALK=3, PED_FLASH=4, PED_CLEAR=5. Codes 6 and 7 are illegal and go to CAR_GREEN on the next edge.
- The timer clears on every state change. Otherwise it increments.
- CAR_GREEN: the timer saturates at T_MIN_GREEN-1 and min_done is then set. Go to CAR_YELLOW when request latch=1 and min_done=1.
- CAR_YELLOW: go to ALL_RED when timer=T_YELLOW-1.
- ALL_RED: go to PED_WALK when timer=T_ALL_RED-1.
- PED_WALK: go to PED_FLASH when timer=T_WALK-1. Without the macro, go to PED_CLEAR instead.
- PED_FLASH: go to PED_CLEAR when timer=T_FLASH-1.
- PED_CLEAR: go to CAR_GREEN when timer=T_ALL_RED-1.
- Request latch:
  - Set by ped_request in every state except PED_WALK, where the pulse is ignored.
  - Cleared on the edge that enters PED_WALK. A coincident pulse on that edge loses; clear wins.
  - Pulses in PED_FLASH or PED_CLEAR are latched and served after the next minimum green.
- Lamp decode is Moore, from the state register only:
  - CAR_GREEN: car_green, ped_red.
  - CAR_YELLOW: car_yellow, ped_red.
  - ALL_RED and PED_CLEAR: car_red, ped_red.
  - PED_WALK: car_red, ped_green.
  - PED_FLASH: car_red, with ped_green = flash bit and ped_red=0.
- Flash bit: set to 1 on entry to PED_FLASH and toggles every FLASH_HALF cycles.

## Timing

- Reset values: state=CAR_GREEN, timer=0, latch=0, flash bit=0. So car_green=1, ped_red=1, all other lamps 0, ped_wait=0, state=0.
- Reset assertion mid-phase forces these values immediately, asynchronously.
- Each timed state lasts exactly T_x cycles.
- Outputs change on the same edge as the state.
- Pulse at cycle n with min_done already 1: ped_wait=1 from n+1, CAR_YELLOW from n+2.
- Request pending from CAR_GREEN entry: CAR_GREEN lasts exactly T_MIN_GREEN cycles, then CAR_YELLOW.
- No request: CAR_GREEN is held indefinitely and the timer stays saturated.
- Repeated pulses while the latch is set have no effect.

## Configuration

- PED_FLASH_EN defined: the PED_FLASH state exists and behaves as above.
- PED_FLASH_EN undefined:
  - PED_WALK goes directly to PED_CLEAR.
  - State code 4 is illegal and recovers to CAR_GREEN.
  - T_FLASH and FLASH_HALF are unused.
  - No flash logic is synthesised.

## Test plan

Bench parameters: T_MIN_GREEN=8, T_YELLOW=3, T_ALL_RED=2, T_WALK=6, T_FLASH=4, FLASH_HALF=1.

- Reset with no request for 50 cycles -> state=0, car_green=1, ped_red=1, ped_wait=0 throughout.
- Pulse 20 cycles after reset -> ped_wait=1 next cycle, then yellow 3 cycles, all-red 2, walk 6, flash 4 with ped_green 1,0,1,0, clear 2, then car_green. ped_wait falls on walk entry.
- Pulse 2 cycles after reset -> car_green lasts 8 cycles total, then yellow 3 cycles.
- Pulses during PED_WALK, then during PED_CLEAR -> walk pulse ignored. Clear pulse sets ped_wait. Next CAR_GREEN lasts exactly 8 cycles, then a second cycle runs.
- Pulse coincident with the ALL_RED->PED_WALK edge -> ped_wait=0 in PED_WALK, and no second crossing follows.
- rst low for 1 cycle mid-PED_WALK -> lamps immediately car_green=1, ped_red=1, and state=0. Build without PED_FLASH_EN: walk goes straight to clear with 2 cycles of all-red.
